uart_with_fifo_tx: RTL and testbench
====================================

Name: uart_with_fifo_tx

Overview:
Transmit-side counterpart of the UART RX/FIFO path. Other modules push bytes into an internal synchronous FIFO. A serializer pops them one at a time and drives them out as 8N1 UART frames on tx_serial_data. The block sits between on-chip producers and the board TX pin. It shares clk_in and rst with the RX path.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per UART bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4
AW, $clog2(FIFO_DEPTH), derived FIFO pointer width

Ports:
clk_in  input  1  single clock; all logic rising-edge
rst  input  1  asynchronous, active-high reset
tx_en  input  1  enables starting new frames; a frame in flight always completes
wr_en  input  1  push din into FIFO
din  input  8  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH entries
almost_full  output  1  data_count >= FIFO_DEPTH-1
empty  output  1  data_count == 0
data_count  output  AW+1  bytes currently stored in FIFO; excludes the byte being serialized
tx_serial_data  output  1  UART line, registered, idle high
tx_busy  output  1  high from pop cycle through last stop-bit cycle
tx_finish  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset (async assert, sync release):
  - tx_serial_data=1, tx_busy=0, tx_finish=0.
  - FIFO pointers cleared: data_count=0, empty=1, full=0, almost_full=0.
  - Serializer returns to IDLE.
- Reset mid-frame: line goes high immediately; the partial frame is abandoned; queued bytes are discarded.
- FIFO write: accepted when wr_en=1 and full=0 (registered flag at that edge).
  - A write while full is dropped silently, even if a pop occurs in the same cycle.
- FIFO read: internal only; issued by the serializer. Registered output, data valid one cycle after the pop.
- Simultaneous accepted write and pop: data_count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Serializer states IDLE -> LOAD -> START -> DATA -> STOP -> IDLE.
  - IDLE: line high. If tx_en=1 and empty=0, pop and go to LOAD; tx_busy rises this cycle.
  - LOAD: capture FIFO dout into the shift register; clear the bit counter; go to START.
  - START: line 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7.
  - STOP: line 1 for CLKS_PER_BIT cycles; tx_finish pulses on its last cycle; then IDLE.
- Latency: pop at edge N; line low from N+2; frame occupies exactly 10*CLKS_PER_BIT cycles.
- Back-to-back: with the FIFO non-empty and tx_en held, the idle-high gap between stop end and next start is exactly 2 cycles (IDLE, LOAD).
- tx_en low: no new pop. A current frame finishes normally. The FIFO still accepts writes.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads per bit. Width $clog2(CLKS_PER_BIT).
- Empty after a pop: the serializer returns to IDLE; tx_busy falls the cycle after tx_finish.

Decomposition:
- Shared package uart_pkg:
  - serializer state enum
  - START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8
  - default CLKS_PER_BIT
- One sub-module, uart_tx: the serializer and baud counter.
  - Interface: tx_start/tx_data in; tx_serial_data, tx_busy, tx_finish out.
- FIFO is inline RTL (register array plus pointers), with no vendor IP.

Test Plan:
1. Single byte, CLKS_PER_BIT=4. Write 0x55, hold tx_en=1.
   -> Line low from pop+2. Then 1,0,1,0,1,0,1,0 at 4 cycles each, stop high. tx_finish pulses once at cycle pop+41. data_count returns to 0.
2. Fill with tx_en=0. Write 0x00..0x0F, then 0xFF.
   -> full=1 after 16 writes; almost_full=1 at count 15; 0xFF dropped. After enabling, exactly 16 frames go out, carrying 0x00..0x0F in order.
3. Back-to-back. Queue 0xA5 and 0x3C, tx_en=1.
   -> Two frames with exactly 2 idle-high cycles between the stop of 0xA5 and the start of 0x3C. Decoded bytes are 0xA5 then 0x3C.
4. tx_en deasserted mid-frame of 0x81.
   -> Frame completes with tx_finish. No further pop while 2 bytes remain queued; data_count=2 stays stable.
5. Write at full coinciding with a pop.
   -> The write is dropped; data_count goes 16 -> 15. The byte sequence afterwards shows no duplication and no loss of earlier entries.
6. Assert rst during data bit 3 of 0xC3 with 5 bytes queued.
   -> tx_serial_data=1 asynchronously; data_count=0, empty=1, tx_busy=0. After release, no frame starts until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and serializer state encoding.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer with per-bit baud counter; line and status are registered.
module uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_serial_data,
  output logic       tx_busy,
  output logic       tx_finish
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic bit_end;
  assign bit_end = cnt == LAST;
  // The line register follows the state one cycle later, so each bit is visible for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx_serial_data <= STOP_BIT;
      tx_busy <= 1'b0;
      tx_finish <= 1'b0;
    end else begin
      tx_busy <= tx_start || state != IDLE;
      tx_finish <= state == STOP && bit_end;
      cnt <= (state inside {START, DATA, STOP}) && !bit_end ? cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          tx_serial_data <= STOP_BIT;
          if (tx_start) state <= LOAD;
        end
        LOAD: begin
          shreg <= tx_data;
          bit_idx <= '0;
          state <= START;
        end
        START: begin
          tx_serial_data <= START_BIT;
          if (bit_end) state <= DATA;
        end
        DATA: begin
          tx_serial_data <= shreg[bit_idx];
          if (bit_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          tx_serial_data <= STOP_BIT;
          if (bit_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_with_fifo_tx.sv
// uart_with_fifo_tx: synchronous byte FIFO feeding an 8N1 UART serializer.
module uart_with_fifo_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        wr_en,
  input  logic [7:0]  din,
  output logic        full,
  output logic        almost_full,
  output logic        empty,
  output logic [AW:0] data_count,
  output logic        tx_serial_data,
  output logic        tx_busy,
  output logic        tx_finish
);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] dout;
  logic wr_ok, pop;
  assign full = data_count == (AW+1)'(FIFO_DEPTH);
  assign almost_full = data_count >= (AW+1)'(FIFO_DEPTH - 1);
  assign empty = data_count == '0;
  assign wr_ok = wr_en && !full;
  // The serializer is idle exactly when it is not busy, or in the single cycle after a stop bit.
  assign pop = tx_en && !empty && (!tx_busy || tx_finish);
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout <= '0;
      data_count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout <= mem[rd_ptr];
      end
      data_count <= data_count + (AW+1)'(wr_ok) - (AW+1)'(pop);
    end
  always_ff @(posedge clk_in)
    if (wr_ok) mem[wr_ptr] <= din;
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_in(clk_in),
    .rst(rst),
    .tx_start(pop),
    .tx_data(dout),
    .tx_serial_data(tx_serial_data),
    .tx_busy(tx_busy),
    .tx_finish(tx_finish)
  );
endmodule

// File: tb/tb_uart_with_fifo_tx.sv
// tb_uart_with_fifo_tx: scoreboard bench; a line monitor decodes frames and compares them with queued bytes.
module tb_uart_with_fifo_tx;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] din = '0;
  logic full, almost_full, empty, tx_serial_data, tx_busy, tx_finish;
  logic [4:0] data_count;
  int checks = 0;
  int errors = 0;
  int frames_started = 0;
  int frames_done = 0;
  int last_gap = 0;
  logic [7:0] sb_q [$];

  uart_with_fifo_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .tx_en(tx_en),
    .wr_en(wr_en),
    .din(din),
    .full(full),
    .almost_full(almost_full),
    .empty(empty),
    .data_count(data_count),
    .tx_serial_data(tx_serial_data),
    .tx_busy(tx_busy),
    .tx_finish(tx_finish)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit acc);
    din = d;
    wr_en = 1'b1;
    if (acc) sb_q.push_back(d);
    @(negedge clk_in);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int b;
    b = 0;
    while (frames_done < n && b < budget) begin
      @(negedge clk_in);
      b++;
    end
    check("frame_timeout", 64'(frames_done >= n), 1);
  endtask

  // Line monitor: captures 40 samples from the first low sample and checks the whole frame shape.
  initial begin
    logic [39:0] ln, fn, pat;
    logic [7:0] exp_b, dec;
    int mcyc, last_end;
    bit aborted;
    mcyc = 0;
    last_end = 0;
    forever begin
      @(negedge clk_in);
      mcyc++;
      if (!rst && tx_serial_data === 1'b0) begin
        frames_started++;
        last_gap = mcyc - last_end;
        ln = '0;
        fn = '0;
        fn[0] = tx_finish;
        aborted = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk_in);
          mcyc++;
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          ln[i] = tx_serial_data;
          fn[i] = tx_finish;
        end
        if (!aborted) begin
          last_end = mcyc + 1;
          exp_b = 8'hxx;
          if (sb_q.size() > 0) exp_b = sb_q.pop_front();
          else check("unexpected_frame", 1, 0);
          for (int j = 0; j < 8; j++) dec[j] = ln[6 + 4 * j];
          for (int i = 0; i < 40; i++) pat[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : exp_b[(i - 4) / 4];
          check("byte", 64'(dec), 64'(exp_b));
          check("frame_shape", 64'(ln), 64'(pat));
          check("finish_pulse", 64'(fn), 64'h80_0000_0000);
          frames_done++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f0, b;
    repeat (3) @(negedge clk_in);
    check("rst_line", 64'(tx_serial_data), 1);
    check("rst_busy", 64'(tx_busy), 0);
    check("rst_finish", 64'(tx_finish), 0);
    check("rst_count", 64'(data_count), 0);
    check("rst_flags", 64'({empty, full, almost_full}), 64'b100);
    rst = 1'b0;
    @(negedge clk_in);
    // single byte and pop-to-start latency
    tx_en = 1'b1;
    wr(8'h55, 1);
    check("t1_count_pre_pop", 64'(data_count), 1);
    @(negedge clk_in);
    check("t1_busy_at_pop", 64'(tx_busy), 1);
    check("t1_count_post_pop", 64'(data_count), 0);
    n = 2;
    while (tx_serial_data !== 1'b0 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check("t1_start_latency", 64'(n), 4);
    wait_done(1, 100);
    @(negedge clk_in);
    check("t1_busy_after", 64'(tx_busy), 0);
    check("t1_line_idle", 64'(tx_serial_data), 1);
    // fill to full with serializer disabled
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1);
      if (i == 14) check("t2_af_at15", 64'({almost_full, full}), 64'b10);
      if (i == 15) check("t2_full_at16", 64'({almost_full, full}), 64'b11);
    end
    wr(8'hFF, 0);
    check("t2_count_after_drop", 64'(data_count), 16);
    tx_en = 1'b1;
    wait_done(17, 16 * 45 + 50);
    check("t2_drained", 64'(data_count), 0);
    check("t2_sb_empty", 64'(sb_q.size()), 0);
    // back-to-back gap
    tx_en = 1'b0;
    wr(8'hA5, 1);
    wr(8'h3C, 1);
    tx_en = 1'b1;
    wait_done(19, 120);
    check("t3_gap", 64'(last_gap), 2);
    // tx_en dropped mid-frame
    @(negedge clk_in);
    wr(8'h81, 1);
    wr(8'h11, 1);
    wr(8'h22, 1);
    repeat (15) @(negedge clk_in);
    tx_en = 1'b0;
    wait_done(20, 60);
    repeat (60) @(negedge clk_in);
    check("t4_count_held", 64'(data_count), 2);
    check("t4_no_new_frame", 64'(frames_started), 20);
    check("t4_busy_low", 64'(tx_busy), 0);
    tx_en = 1'b1;
    wait_done(22, 120);
    // write at full coinciding with a pop
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 1);
    tx_en = 1'b1;
    wr(8'hEE, 0);
    check("t5_count_16_to_15", 64'(data_count), 15);
    wait_done(38, 16 * 45 + 50);
    check("t5_drained", 64'(data_count), 0);
    check("t5_sb_empty", 64'(sb_q.size()), 0);
    // reset during data bit 3
    tx_en = 1'b0;
    wr(8'hC3, 1);
    for (int i = 1; i <= 5; i++) wr(8'(i), 1);
    f0 = frames_started;
    tx_en = 1'b1;
    b = 0;
    while (frames_started == f0 && b < 20) begin
      @(negedge clk_in);
      b++;
    end
    check("t6_frame_began", 64'(frames_started), 64'(f0 + 1));
    repeat (17) @(negedge clk_in);
    check("t6_line_bit3", 64'(tx_serial_data), 0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_line", 64'(tx_serial_data), 1);
    check("t6_async_count", 64'(data_count), 0);
    check("t6_async_empty", 64'(empty), 1);
    check("t6_async_busy", 64'(tx_busy), 0);
    sb_q.delete();
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (60) @(negedge clk_in);
    check("t6_no_restart", 64'(frames_started), 64'(f0 + 1));
    check("t6_line_idle", 64'(tx_serial_data), 1);
    wr(8'h5A, 1);
    wait_done(39, 100);
    check("t6_sb_empty", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
